// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard
// ----------------------------------------------------------------------------
// Purpose:
//   DEPTH = 2**ADDR_W entry register file with two asynchronous read ports,
//   one write port, and a per-register scoreboard "busy" bit. An issue marks
//   a destination register busy and a later write-back clears it. A
//   sequential clear engine walks every register, one per cycle, zeroing
//   both data and busy bits.
//
// Parameters:
//   DATA_W   - register width in bits
//   ADDR_W   - register select width (DEPTH = 2**ADDR_W)
//   ZERO_REG - 1: register 0 reads as zero, is never busy, and ignores
//              writes and issues
//   BYPASS   - 1: a write in progress is forwarded to a read of the same
//              register in the same cycle
//
// Ports:
//   i_clk                      clock, all state updates on the rising edge
//   i_rst_n                    asynchronous active-low reset
//   i_rd_addr1 / i_rd_addr2    read port register selects
//   o_rd_data1 / o_rd_data2    read data (combinational)
//   o_rd_busy1 / o_rd_busy2    busy bit of the selected register (combinational)
//   i_wr_en, i_wr_addr,
//   i_wr_data                  write port; a write also clears the busy bit
//   i_issue_en, i_issue_addr   mark a register busy
//   i_clr_req                  start the clear sequence
//   o_clr_busy                 high while the clear sequence runs
//   o_clr_done                 one-cycle pulse when the clear sequence ends
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    output logic              o_rd_busy1,
    output logic              o_rd_busy2,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_issue_en,
    input  logic [ADDR_W-1:0] i_issue_addr,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BYP   = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_idx;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic              w_idle;
    logic              w_wr_ok;
    logic              w_iss_ok;
    logic [DEPTH-1:0]  w_wr_sel;
    logic [DEPTH-1:0]  w_iss_sel;
    logic [DEPTH-1:0]  w_clr_sel;

    // ------------------------------------------------------------------------
    // Command qualification. Everything user-driven is frozen while the clear
    // engine owns the array; the hardwired zero register swallows writes and
    // issues so it can never become nonzero or busy.
    // ------------------------------------------------------------------------
    assign w_idle   = (r_state == S_IDLE);
    assign w_wr_ok  = i_wr_en    && w_idle && !(ZR && (i_wr_addr    == '0));
    assign w_iss_ok = i_issue_en && w_idle && !(ZR && (i_issue_addr == '0));

    // Per-register one-hot selects for write, issue and clear.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign w_wr_sel[gi]  = w_wr_ok  && (i_wr_addr    == ADDR_W'(gi));
            assign w_iss_sel[gi] = w_iss_ok && (i_issue_addr == ADDR_W'(gi));
            assign w_clr_sel[gi] = (r_state == S_CLEAR) && (r_idx == ADDR_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Register array and scoreboard. Reset must clear every entry at once,
    // so storage is flops rather than a RAM macro.
    // When a write and an issue hit the same register, the issue sets the
    // busy bit: the new producer is already in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_clr_sel[i]) begin
                    r_mem[i]  <= '0;
                    r_busy[i] <= 1'b0;
                end else begin
                    if (w_wr_sel[i]) begin
                        r_mem[i] <= i_wr_data;
                    end
                    if (w_iss_sel[i]) begin
                        r_busy[i] <= 1'b1;
                    end else if (w_wr_sel[i]) begin
                        r_busy[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Clear FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_clr_req) w_state_next = S_CLEAR;
            S_CLEAR: if (r_idx == LAST_IDX) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        o_clr_busy = 1'b0;
        o_clr_done = 1'b0;
        case (r_state)
            S_CLEAR: o_clr_busy = 1'b1;
            S_DONE: begin
                o_clr_busy = 1'b1;
                o_clr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Walk index: restarts at 0 outside CLEAR and returns to 0 after the last
    // entry instead of rolling over into a second pass.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
        end else if (r_state == S_CLEAR) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end else begin
            r_idx <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports. Forwarding is gated with the reset input so that outputs
    // stay at zero while reset is held even if a write is presented.
    // When a forwarded write collides with an issue to the same register,
    // the forwarded busy bit reflects the value it will take after the edge.
    // ------------------------------------------------------------------------
    logic [1:0][ADDR_W-1:0] w_rd_addr;
    logic [1:0][DATA_W-1:0] w_rd_data;
    logic [1:0]             w_rd_busy;
    logic [1:0]             w_rd_zero;
    logic [1:0]             w_fwd;

    assign w_rd_addr[0] = i_rd_addr1;
    assign w_rd_addr[1] = i_rd_addr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign w_rd_zero[gi] = ZR && (w_rd_addr[gi] == '0);
            assign w_fwd[gi]     = BYP && i_rst_n && w_wr_ok &&
                                   (i_wr_addr == w_rd_addr[gi]);
            assign w_rd_data[gi] = w_rd_zero[gi] ? '0 :
                                   w_fwd[gi]     ? i_wr_data :
                                                   r_mem[w_rd_addr[gi]];
            assign w_rd_busy[gi] = w_rd_zero[gi] ? 1'b0 :
                                   w_fwd[gi]     ? (w_iss_ok && (i_issue_addr == w_rd_addr[gi])) :
                                                   r_busy[w_rd_addr[gi]];
        end
    endgenerate

    assign o_rd_data1 = w_rd_data[0];
    assign o_rd_data2 = w_rd_data[1];
    assign o_rd_busy1 = w_rd_busy[0];
    assign o_rd_busy2 = w_rd_busy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n      = 1'b0;
    logic [AW-1:0] rd_addr1   = '0;
    logic [AW-1:0] rd_addr2   = '0;
    logic          wr_en      = 1'b0;
    logic [AW-1:0] wr_addr    = '0;
    logic [DW-1:0] wr_data    = '0;
    logic          issue_en   = 1'b0;
    logic [AW-1:0] issue_addr = '0;
    logic          clr_req    = 1'b0;

    logic [DW-1:0] d1_b, d2_b, d1_n, d2_n;
    logic          b1_b, b2_b, b1_n, b2_n;
    logic          cb_b, cd_b, cb_n, cd_n;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
        .o_rd_data1(d1_b), .o_rd_data2(d2_b),
        .o_rd_busy1(b1_b), .o_rd_busy2(b2_b),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_issue_en(issue_en), .i_issue_addr(issue_addr),
        .i_clr_req(clr_req), .o_clr_busy(cb_b), .o_clr_done(cd_b)
    );

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
        .o_rd_data1(d1_n), .o_rd_data2(d2_n),
        .o_rd_busy1(b1_n), .o_rd_busy2(b2_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_issue_en(issue_en), .i_issue_addr(issue_addr),
        .i_clr_req(clr_req), .o_clr_busy(cb_n), .o_clr_done(cd_n)
    );

    // ------------------------------------------------------------------
    // Reference model: architectural contents, busy flags, and a clear
    // phase counter (0 = idle, 1..DEPTH = clearing entry phase-1,
    // DEPTH+1 = done cycle).
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    int            m_phase = 0;

    typedef struct packed {
        logic [31:0]   id;
        logic [DW-1:0] d1b, d2b, d1n, d2n;
        logic          b1b, b2b, b1n, b2n;
        logic          cb, cd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_txn  = 0;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_phase = 0;
    endtask

    function automatic logic fwd_hit(input logic [AW-1:0] a, input bit byp);
        return byp && rst_n && (m_phase == 0) && wr_en && (wr_addr == a);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (fwd_hit(a, byp)) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (fwd_hit(a, byp)) return issue_en && (issue_addr == a);
        return m_busy[a];
    endfunction

    // Effect of the upcoming rising edge on the model.
    task automatic model_edge();
        if (!rst_n) return;
        if (m_phase == 0) begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
            if (clr_req) m_phase = 1;
        end else if (m_phase <= DEPTH) begin
            m_mem[m_phase-1]  = '0;
            m_busy[m_phase-1] = 1'b0;
            m_phase++;
        end else begin
            m_phase = 0;
        end
    endtask

    // Drive one cycle of stimulus and queue the expected response.
    task automatic step(input bit rs, input bit we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input bit ie, input logic [AW-1:0] ia,
                        input bit cr, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rs; wr_en = we; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_addr = ia; clr_req = cr;
        rd_addr1 = a1; rd_addr2 = a2;
        if (!rs) model_reset();
        e.id  = n_txn;
        e.d1b = exp_data(a1, 1'b1);
        e.d2b = exp_data(a2, 1'b1);
        e.b1b = exp_busy(a1, 1'b1);
        e.b2b = exp_busy(a2, 1'b1);
        e.d1n = exp_data(a1, 1'b0);
        e.d2n = exp_data(a2, 1'b0);
        e.b1n = exp_busy(a1, 1'b0);
        e.b2n = exp_busy(a2, 1'b0);
        e.cb  = (m_phase != 0);
        e.cd  = (m_phase == DEPTH + 1);
        exp_q.push_back(e);
        n_txn++;
        model_edge();
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic rstep(input int clr_pct);
        bit            we, ie, cr;
        logic [AW-1:0] wa, ia, a1, a2;
        logic [DW-1:0] wd;
        we = ($urandom_range(0, 1) == 1);
        ie = ($urandom_range(0, 2) == 0);
        cr = (int'($urandom_range(0, 99)) < clr_pct);
        wa = rnd_addr(); ia = rnd_addr(); a1 = rnd_addr(); a2 = rnd_addr();
        wd = $urandom;
        step(1'b1, we, wa, wd, ie, ia, cr, a1, a2);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops one expectation per presented cycle and compares.
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] id,
                       input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s txn %0d: got %h required %h", nm, id, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("byp_rd_data1", e.id, d1_b, e.d1b);
                chk("byp_rd_data2", e.id, d2_b, e.d2b);
                chk("byp_rd_busy1", e.id, DW'(b1_b), DW'(e.b1b));
                chk("byp_rd_busy2", e.id, DW'(b2_b), DW'(e.b2b));
                chk("byp_clr_busy", e.id, DW'(cb_b), DW'(e.cb));
                chk("byp_clr_done", e.id, DW'(cd_b), DW'(e.cd));
                chk("nob_rd_data1", e.id, d1_n, e.d1n);
                chk("nob_rd_data2", e.id, d2_n, e.d2n);
                chk("nob_rd_busy1", e.id, DW'(b1_n), DW'(e.b1n));
                chk("nob_rd_busy2", e.id, DW'(b2_n), DW'(e.b2n));
                chk("nob_clr_busy", e.id, DW'(cb_n), DW'(e.cb));
                chk("nob_clr_done", e.id, DW'(cd_n), DW'(e.cd));
                $display("txn %0d rst_n=%b wr=%b@%0d issue=%b@%0d clr_req=%b a1=%0d d1=%h b1=%b a2=%0d d2=%h/%h b2=%b clr=%b%b",
                         e.id, rst_n, wr_en, wr_addr, issue_en, issue_addr, clr_req,
                         rd_addr1, d1_b, b1_b, rd_addr2, d2_b, d2_n, b2_b, cb_b, cd_b);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        model_reset();

        // Reset held, including a write that must not be forwarded.
        step(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
        step(1'b0, 1'b1, 5'd4, 32'h55AA55AA, 1'b1, 5'd4, 1'b0, 5'd4, 5'd4);
        step(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd4, 5'd31);

        // r5 write, read back on both ports.
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2);
        step(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd5);

        // Write and issue to r0 are swallowed.
        step(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd5);

        // Same-cycle forwarding on r7 (bypass vs stored value).
        step(1'b1, 1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
        step(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd7);

        // Scoreboard sequence on r9.
        step(1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
        step(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
        step(1'b1, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, 1'b0, 5'd9, 5'd1);
        step(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
        step(1'b1, 1'b1, 5'd9, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd9, 5'd1);
        step(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd9);

        // Random traffic, no clears.
        for (int i = 0; i < 300; i++) rstep(0);

        // Fill r1..r31, then a full clear with ignored traffic during it.
        for (int i = 1; i < DEPTH; i++)
            step(1'b1, 1'b1, AW'(i), 32'h1000_0000 + 32'(i), (i % 3) == 0, AW'(i + 1),
                 1'b0, AW'(i), AW'(i - 1));
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd4);
        for (int i = 0; i < DEPTH + 1; i++)
            step(1'b1, 1'b1, AW'(i), 32'hF0F0_0000 + 32'(i), 1'b1, AW'(i),
                 (i % 4) == 0, AW'(i), AW'(DEPTH - 1 - i));
        for (int i = 0; i < DEPTH / 2; i++)
            step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, AW'(2 * i), AW'(2 * i + 1));

        // Reset asserted ten cycles into a clear.
        for (int i = 16; i < 24; i++)
            step(1'b1, 1'b1, AW'(i), 32'hC0DE_0000 + 32'(i), 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd20, 5'd22);
        for (int i = 0; i < 9; i++)
            step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd20, 5'd22);
        step(1'b0, 1'b1, 5'd20, 32'h77777777, 1'b1, 5'd22, 1'b0, 5'd20, 5'd22);
        step(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd20, 5'd22);
        step(1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd20, 5'd22);
        step(1'b1, 1'b1, 5'd20, 32'hCAFEF00D, 1'b0, 5'd0,  1'b0, 5'd21, 5'd22);
        step(1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd20, 5'd20);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) rstep(2);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2);

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
